mips_pipe_scoreboard: RTL and testbench

//  Parametrised hazard scoreboard for the pipelined MIPS core; generalises the fixed 5-stage hazard logic to

---
 rtl/mips_pipe_scoreboard_pkg.sv | 27 ++
 rtl/mips_pipe_scoreboard_reg_counter.sv | 28 ++
 rtl/mips_pipe_scoreboard.sv | 108 ++++++++++
 tb/tb_mips_pipe_scoreboard.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_scoreboard_pkg.sv
// Shared sizing and latency constants for the issue-stage hazard scoreboard.
package mips_pipe_scoreboard_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned MAX_LAT  = 8;
  localparam int unsigned LAT_W    = 4;
  localparam int unsigned STAT_W   = 32;

  // Result latencies Control drives onto issue_lat per instruction class.
  localparam logic [LAT_W-1:0] LAT_ALU  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(2);
  localparam logic [LAT_W-1:0] LAT_MUL  = LAT_W'(4);
  localparam logic [LAT_W-1:0] LAT_DIV  = LAT_W'(8);

  // Clamp a requested latency into the legal 1..MAX_LAT range.
  function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
    logic [LAT_W-1:0] le;
    le = lat;
    if (lat == '0)
      le = LAT_W'(1);
    else if (lat > LAT_W'(MAX_LAT))
      le = LAT_W'(MAX_LAT);
    return le;
  endfunction

endpackage

// File: rtl/mips_pipe_scoreboard_reg_counter.sv
// Per-register result-in-flight down-counter; a load overrides the decrement.
module mips_sb_reg_counter
  import mips_pipe_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  output logic [LAT_W-1:0] o_cnt,
  output logic             o_busy
);

  logic [LAT_W-1:0] r_cnt;

  // Count down to zero; a new reservation reloads the remaining latency.
  always_ff @(posedge clk) begin
    if (i_reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - LAT_W'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/mips_pipe_scoreboard.sv
// Issue-stage hazard scoreboard: RAW/WAW on in-flight destinations plus
// single writeback-port reservation, with a saturating stall statistic.
module mips_pipe_scoreboard
  import mips_pipe_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_issue_valid,
  input  logic [REG_AW-1:0]   i_issue_rs,
  input  logic                i_issue_rs_used,
  input  logic [REG_AW-1:0]   i_issue_rt,
  input  logic                i_issue_rt_used,
  input  logic [REG_AW-1:0]   i_issue_dst,
  input  logic                i_issue_wr,
  input  logic [LAT_W-1:0]    i_issue_lat,
  input  logic                i_flush,
  output logic                o_issue_stall,
  output logic                o_issue_accept,
  output logic [NUM_REGS-1:0] o_busy_vec,
  output logic                o_lat_err,
  output logic [STAT_W-1:0]   o_stall_count
);

  logic [LAT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic [LAT_W-1:0]    w_le;
  logic [LAT_W-1:0]    w_le_m1;
  logic                w_lat_bad;
  logic                w_raw;
  logic                w_waw;
  logic                w_wbp;
  logic                w_stall;
  logic                w_accept;
  logic                w_reserve;
  logic [MAX_LAT-1:0]  w_slot_shift;
  logic [MAX_LAT-1:0]  w_slot_new;

  logic [MAX_LAT-1:0]  r_slot;
  logic                r_lat_err;
  logic [STAT_W-1:0]   r_stall_count;

  // Register 0 is hardwired and never carries a pending result.
  assign w_cnt[0]  = '0;
  assign w_busy[0] = 1'b0;

  // One pending-result counter per tracked architectural register.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    mips_sb_reg_counter u_cnt (
      .clk        (clk),
      .i_reset    (i_reset),
      .i_load     (w_reserve && (i_issue_dst == REG_AW'(g))),
      .i_load_val (w_le_m1),
      .o_cnt      (w_cnt[g]),
      .o_busy     (w_busy[g])
    );
  end

  // Hazard evaluation against the pre-edge scoreboard state.
  always_comb begin
    w_le         = eff_lat(i_issue_lat);
    w_le_m1      = w_le - LAT_W'(1);
    w_lat_bad    = (i_issue_lat == '0) || (i_issue_lat > LAT_W'(MAX_LAT));
    w_raw        = (i_issue_rs_used && w_busy[i_issue_rs]) ||
                   (i_issue_rt_used && w_busy[i_issue_rt]);
    w_waw        = i_issue_wr && w_busy[i_issue_dst] &&
                   (w_cnt[i_issue_dst] >= w_le_m1);
    // Shifting past the top bit yields zero, so Le==MAX_LAT never conflicts.
    w_slot_shift = r_slot >> w_le;
    w_wbp        = i_issue_wr && (w_le < LAT_W'(MAX_LAT)) && w_slot_shift[0];
    w_stall      = i_issue_valid && (w_raw || w_waw || w_wbp);
    w_accept     = i_issue_valid && !w_stall && !i_flush;
    w_reserve    = w_accept && i_issue_wr && (i_issue_dst != '0);
    w_slot_new   = '0;
    if (w_accept && i_issue_wr)
      w_slot_new = MAX_LAT'(1) << w_le_m1;
  end

  // Writeback-port reservation shift register.
  always_ff @(posedge clk) begin
    if (i_reset)
      r_slot <= '0;
    else
      r_slot <= (r_slot >> 1) | w_slot_new;
  end

  // Sticky flag for an accepted out-of-range latency.
  always_ff @(posedge clk) begin
    if (i_reset)
      r_lat_err <= 1'b0;
    else if (w_accept && w_lat_bad)
      r_lat_err <= 1'b1;
  end

  // Saturating count of genuine (non-flushed) stall cycles.
  always_ff @(posedge clk) begin
    if (i_reset)
      r_stall_count <= '0;
    else if (w_stall && !i_flush && (r_stall_count != '1))
      r_stall_count <= r_stall_count + STAT_W'(1);
  end

  assign o_issue_stall  = w_stall;
  assign o_issue_accept = w_accept;
  assign o_busy_vec     = w_busy;
  assign o_lat_err      = r_lat_err;
  assign o_stall_count  = r_stall_count;

endmodule

// File: tb/tb_mips_pipe_scoreboard.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares.
module tb_mips_pipe_scoreboard;
  import mips_pipe_scoreboard_pkg::*;

  logic                clk;
  logic                i_reset;
  logic                i_issue_valid;
  logic [REG_AW-1:0]   i_issue_rs;
  logic                i_issue_rs_used;
  logic [REG_AW-1:0]   i_issue_rt;
  logic                i_issue_rt_used;
  logic [REG_AW-1:0]   i_issue_dst;
  logic                i_issue_wr;
  logic [LAT_W-1:0]    i_issue_lat;
  logic                i_flush;
  logic                o_issue_stall;
  logic                o_issue_accept;
  logic [NUM_REGS-1:0] o_busy_vec;
  logic                o_lat_err;
  logic [STAT_W-1:0]   o_stall_count;

  mips_pipe_scoreboard dut (
    .clk             (clk),
    .i_reset         (i_reset),
    .i_issue_valid   (i_issue_valid),
    .i_issue_rs      (i_issue_rs),
    .i_issue_rs_used (i_issue_rs_used),
    .i_issue_rt      (i_issue_rt),
    .i_issue_rt_used (i_issue_rt_used),
    .i_issue_dst     (i_issue_dst),
    .i_issue_wr      (i_issue_wr),
    .i_issue_lat     (i_issue_lat),
    .i_flush         (i_flush),
    .o_issue_stall   (o_issue_stall),
    .o_issue_accept  (o_issue_accept),
    .o_busy_vec      (o_busy_vec),
    .o_lat_err       (o_lat_err),
    .o_stall_count   (o_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          stall;
    bit          accept;
    bit [31:0]   busy;
    bit          lat_err;
    bit [31:0]   sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model in absolute time: a register is busy until its result
  // time, and each writeback reservation is remembered as a result time.
  int      t = 0;
  int      done_t [NUM_REGS];
  int      wb_q[$];
  bit      m_lat_err = 0;
  longint  m_sc = 0;

  function automatic bit m_busy(input int r);
    return (r != 0) && (done_t[r] > t);
  endfunction

  function automatic int m_cnt(input int r);
    return m_busy(r) ? done_t[r] - t : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want, input int cyc);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Monitor: compare every cycle that has a pushed expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue_stall",  32'(o_issue_stall),  32'(e.stall),   e.cyc);
        check("issue_accept", 32'(o_issue_accept), 32'(e.accept),  e.cyc);
        check("busy_vec",     o_busy_vec,          e.busy,         e.cyc);
        check("lat_err",      32'(o_lat_err),      32'(e.lat_err), e.cyc);
        check("stall_count",  o_stall_count,       e.sc,           e.cyc);
      end
    end
  end

  // Drive one cycle, push the model's expectation, advance the model.
  task automatic drive(input bit v, input int rs, input bit rsu, input int rt,
                       input bit rtu, input int dst, input bit wr, input int lat,
                       input bit fl, input bit rst);
    exp_t e;
    int   le;
    bit   raw, waw, wbp, stall, acc, bad;
    i_issue_valid   = v;
    i_issue_rs      = REG_AW'(rs);
    i_issue_rs_used = rsu;
    i_issue_rt      = REG_AW'(rt);
    i_issue_rt_used = rtu;
    i_issue_dst     = REG_AW'(dst);
    i_issue_wr      = wr;
    i_issue_lat     = LAT_W'(lat);
    i_flush         = fl;
    i_reset         = rst;

    bad = (lat == 0) || (lat > int'(MAX_LAT));
    le  = (lat == 0) ? 1 : ((lat > int'(MAX_LAT)) ? int'(MAX_LAT) : lat);
    raw = (rsu && m_busy(rs)) || (rtu && m_busy(rt));
    waw = wr && m_busy(dst) && (m_cnt(dst) >= le - 1);
    wbp = 1'b0;
    if (wr && le < int'(MAX_LAT))
      foreach (wb_q[k]) if (wb_q[k] - t == le) wbp = 1'b1;
    stall = v && (raw || waw || wbp);
    acc   = v && !stall && !fl;

    e.cyc = t; e.stall = stall; e.accept = acc; e.lat_err = m_lat_err;
    e.sc  = 32'(m_sc);
    e.busy = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) e.busy[r] = m_busy(r);
    exp_q.push_back(e);

    if (rst) begin
      foreach (done_t[r]) done_t[r] = 0;
      wb_q.delete();
      m_lat_err = 0;
      m_sc = 0;
    end else begin
      if (stall && !fl && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (acc && bad) m_lat_err = 1;
      if (acc && wr) begin
        wb_q.push_back(t + le);
        if (dst != 0) done_t[dst] = t + le;
      end
    end
    t++;
    for (int k = wb_q.size() - 1; k >= 0; k--)
      if (wb_q[k] < t) wb_q.delete(k);

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    int rs, rt, dst, lat, pick;
    bit v, fl, rst;
    foreach (done_t[r]) done_t[r] = 0;
    i_reset = 1'b1; i_issue_valid = 0; i_issue_rs = '0; i_issue_rs_used = 0;
    i_issue_rt = '0; i_issue_rt_used = 0; i_issue_dst = '0; i_issue_wr = 0;
    i_issue_lat = LAT_W'(1); i_flush = 0;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;

    idle(1);
    // ALU result forwarded back-to-back.
    drive(1, 1, 1, 2, 1, 8, 1, 1, 0, 0);
    drive(1, 8, 1, 0, 0, 9, 1, 1, 0, 0);
    idle(2);
    // Load-use: one stall then accept.
    drive(1, 1, 1, 0, 0, 9, 1, 2, 0, 0);
    repeat (2) drive(1, 9, 1, 0, 0, 16, 1, 1, 0, 0);
    idle(2);
    // WAW behind a multiply.
    drive(1, 1, 1, 2, 1, 10, 1, 4, 0, 0);
    repeat (4) drive(1, 3, 1, 0, 0, 10, 1, 1, 0, 0);
    idle(5);
    // Writeback-port conflict between mul and a later load.
    drive(1, 1, 1, 2, 1, 11, 1, 4, 0, 0);
    idle(1);
    repeat (2) drive(1, 1, 1, 0, 0, 12, 1, 2, 0, 0);
    idle(5);
    // Flush during a RAW hazard; older load still drains.
    drive(1, 1, 1, 0, 0, 13, 1, 2, 0, 0);
    drive(1, 13, 1, 0, 0, 17, 1, 1, 1, 0);
    idle(3);
    // Out-of-range divide latency, then reset mid-flight.
    drive(1, 1, 1, 2, 1, 14, 1, 9, 0, 0);
    idle(3);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 14, 1, 0, 0, 15, 1, 1, 0, 0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      v    = ($urandom % 4) != 0;
      rs   = ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 8);
      rt   = int'($urandom % 8);
      dst  = ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 8);
      pick = int'($urandom % 8);
      case (pick)
        0: lat = 0;
        1: lat = 1;
        2: lat = 2;
        3: lat = 4;
        4: lat = 8;
        5: lat = 9 + int'($urandom % 7);
        default: lat = int'($urandom % 16);
      endcase
      fl  = ($urandom % 10) == 0;
      rst = ($urandom % 250) == 0;
      drive(v, rs, $urandom % 2 == 0, rt, $urandom % 2 == 0, dst,
            $urandom % 4 != 0, lat, fl, rst);
    end
    idle(1);

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0, t);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
